// File: rtl/parameter_dispatcher_pkg.sv
// Shared constants and helpers for the parameter dispatcher.
// Context entries are packed as {valid, pe_id, rf_offset}.
package parameter_dispatcher_pkg;

  localparam int unsigned DEF_PARAMETER_WIDTH = 32;
  localparam int unsigned DEF_PE_ID_WIDTH     = 2;
  localparam int unsigned DEF_RF_WIDTH        = 6;
  localparam int unsigned DEF_ID_WIDTH        = 8;
  localparam int unsigned DEF_COUNT_WIDTH     = 8;

  localparam logic CTX_VLD_RST = 1'b0;

  function automatic int unsigned ctx_valid_pos(
    input int unsigned pe_w,
    input int unsigned rf_w
  );
    return pe_w + rf_w;
  endfunction

  function automatic logic [63:0] sat_max(
    input int unsigned w
  );
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/parameter_dispatcher_context.sv
// Context table: un-reset data array, reset valid vector,
// registered read with enable; reads see the pre-write entry.
module parameter_context_table
  import parameter_dispatcher_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
  parameter int unsigned PE_ID_WIDTH = DEF_PE_ID_WIDTH,
  parameter int unsigned RF_WIDTH    = DEF_RF_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             we_i,
  input  logic [ID_WIDTH-1:0]              waddr_i,
  input  logic [PE_ID_WIDTH+RF_WIDTH:0]    wdata_i,
  input  logic                             re_i,
  input  logic [ID_WIDTH-1:0]              raddr_i,
  output logic                             rd_valid_o,
  output logic [PE_ID_WIDTH+RF_WIDTH-1:0]  rd_dest_o
);

  localparam int unsigned DEPTH   = 1 << ID_WIDTH;
  localparam int unsigned DEST_W  = PE_ID_WIDTH + RF_WIDTH;
  localparam int unsigned VLD_POS =
    ctx_valid_pos(PE_ID_WIDTH, RF_WIDTH);

  logic [DEST_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DEST_W-1:0] rd_dest_q, rd_dest_d;

  always_comb begin
    vld_d      = vld_q;
    rd_valid_d = rd_valid_q;
    rd_dest_d  = rd_dest_q;
    if (re_i) begin
      rd_valid_d = vld_q[raddr_i];
      rd_dest_d  = mem_q[raddr_i];
    end
    if (we_i) begin
      vld_d[waddr_i] = wdata_i[VLD_POS];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i[DEST_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= {DEPTH{CTX_VLD_RST}};
      rd_valid_q <= CTX_VLD_RST;
      rd_dest_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      rd_valid_q <= rd_valid_d;
      rd_dest_q  <= rd_dest_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_dest_o  = rd_dest_q;

endmodule

// File: rtl/parameter_dispatcher.sv
// Parameter dispatcher: ID -> context lookup, two-stage
// pipeline into the CGRA parameter buffer, drop/hybrid counters.
module parameter_dispatcher
  import parameter_dispatcher_pkg::*;
#(
  parameter int unsigned PARAMETER_WIDTH = DEF_PARAMETER_WIDTH,
  parameter int unsigned PE_ID_WIDTH     = DEF_PE_ID_WIDTH,
  parameter int unsigned RF_WIDTH        = DEF_RF_WIDTH,
  parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
  parameter int unsigned COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                            CGRA_CLK_I,
  input  logic                            RST_N_I,
  input  logic                            EN_I,
  input  logic                            PARAM_VALID_I,
  output logic                            PARAM_READY_O,
  input  logic [PARAMETER_WIDTH-1:0]      PARAM_DATA_I,
  input  logic [ID_WIDTH-1:0]             PARAM_ID_I,
  input  logic                            PARAM_HYBRID_I,
  input  logic                            CTX_WE_I,
  input  logic [ID_WIDTH-1:0]             CTX_ADDR_I,
  input  logic [PE_ID_WIDTH+RF_WIDTH:0]   CTX_DATA_I,
  input  logic                            FLUSH_I,
  input  logic                            SYNC_IN_I,
  input  logic                            CLEAR_ERROR_I,
  input  logic                            FULL_I,
  output logic                            WRITE_EN_O,
  output logic [PARAMETER_WIDTH-1:0]      DATA_O,
  output logic [PE_ID_WIDTH+RF_WIDTH-1:0] DESTINATION_O,
  output logic                            IS_HYBRID_PARAMETER_O,
  output logic                            ERROR_O,
  output logic [COUNT_WIDTH-1:0]          DROP_CNT_O,
  output logic [COUNT_WIDTH-1:0]          HYBRID_CNT_O
);

  localparam int unsigned DEST_W = PE_ID_WIDTH + RF_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX =
    COUNT_WIDTH'(sat_max(COUNT_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    COUNT_WIDTH'(1);

  logic                       s1_valid_q, s1_valid_d;
  logic [PARAMETER_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                       s1_hybrid_q, s1_hybrid_d;

  logic                       s2_valid_q, s2_valid_d;
  logic [PARAMETER_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [DEST_W-1:0]          s2_dest_q, s2_dest_d;
  logic                       s2_hybrid_q, s2_hybrid_d;

  logic [COUNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;
  logic [COUNT_WIDTH-1:0]     hyb_cnt_q, hyb_cnt_d;
  logic                       error_q, error_d;

  logic              ctx_vld;
  logic [DEST_W-1:0] ctx_dest;

  logic write_en;
  logic s2_free;
  logic s1_xfer;
  logic s2_load;
  logic drop;
  logic ready;
  logic accept;

  parameter_context_table #(
    .ID_WIDTH    (ID_WIDTH),
    .PE_ID_WIDTH (PE_ID_WIDTH),
    .RF_WIDTH    (RF_WIDTH)
  ) u_ctx (
    .clk_i      (CGRA_CLK_I),
    .rst_ni     (RST_N_I),
    .we_i       (EN_I & CTX_WE_I),
    .waddr_i    (CTX_ADDR_I),
    .wdata_i    (CTX_DATA_I),
    .re_i       (accept),
    .raddr_i    (PARAM_ID_I),
    .rd_valid_o (ctx_vld),
    .rd_dest_o  (ctx_dest)
  );

  // The S1 context is the table's registered read of this word.
  always_comb begin
    write_en = EN_I & ~FLUSH_I & s2_valid_q & ~FULL_I;
    s2_free  = ~s2_valid_q | write_en;
    s1_xfer  = EN_I & ~FLUSH_I & s1_valid_q & s2_free;
    s2_load  = s1_xfer & ctx_vld;
    drop     = s1_xfer & ~ctx_vld;
    ready    = EN_I & ~FLUSH_I & (~s1_valid_q | s1_xfer);
    accept   = ready & PARAM_VALID_I;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_hybrid_d = s1_hybrid_q;
    if (EN_I) begin
      if (FLUSH_I) begin
        s1_valid_d = 1'b0;
      end else if (accept) begin
        s1_valid_d  = 1'b1;
        s1_data_d   = PARAM_DATA_I;
        s1_hybrid_d = PARAM_HYBRID_I;
      end else if (s1_xfer) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_dest_d   = s2_dest_q;
    s2_hybrid_d = s2_hybrid_q;
    if (EN_I) begin
      if (FLUSH_I) begin
        s2_valid_d = 1'b0;
      end else if (s2_load) begin
        s2_valid_d  = 1'b1;
        s2_data_d   = s1_data_q;
        s2_dest_d   = ctx_dest;
        s2_hybrid_d = s1_hybrid_q;
      end else if (write_en) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  // Clear/sync win over a same-cycle drop/increment.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    error_d    = error_q;
    hyb_cnt_d  = hyb_cnt_q;
    if (EN_I) begin
      if (CLEAR_ERROR_I) begin
        drop_cnt_d = '0;
        error_d    = 1'b0;
      end else if (drop) begin
        error_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
      end
      if (SYNC_IN_I) begin
        hyb_cnt_d = '0;
      end else if (write_en && s2_hybrid_q
                   && hyb_cnt_q != CNT_MAX) begin
        hyb_cnt_d = hyb_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_hybrid_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_dest_q   <= '0;
      s2_hybrid_q <= 1'b0;
      drop_cnt_q  <= '0;
      hyb_cnt_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_hybrid_q <= s1_hybrid_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_dest_q   <= s2_dest_d;
      s2_hybrid_q <= s2_hybrid_d;
      drop_cnt_q  <= drop_cnt_d;
      hyb_cnt_q   <= hyb_cnt_d;
      error_q     <= error_d;
    end
  end

  assign PARAM_READY_O         = ready;
  assign WRITE_EN_O            = write_en;
  assign DATA_O                = s2_data_q;
  assign DESTINATION_O         = s2_dest_q;
  assign IS_HYBRID_PARAMETER_O = s2_hybrid_q;
  assign ERROR_O               = error_q;
  assign DROP_CNT_O            = drop_cnt_q;
  assign HYBRID_CNT_O          = hyb_cnt_q;

endmodule
